// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-memory responder for the CPU's data port. It holds an internal word RAM
// and serves word, halfword and byte stores (byte-lane masked) plus
// sign-extended or zero-extended loads. It also decodes a small MMIO window at
// addr[31:16] == MMIO_TAG. The window holds a free-running cycle counter, an
// LED register and a sticky misaligned-store error record.
//
// Ports
//   clk            system clock, all state changes on the rising edge
//   reset          asynchronous, active-high
//   dmemsrc        access enable (0: loads return 0, stores ignored)
//   dmem_inchoice  store width: 00 none, 01 word, 10 halfword, 11 byte
//   dmem_outchoice load mode: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu
//   dmem_addrin    byte address
//   dmem_in        store data (sub-word data taken from the low bits)
//   dmem_out       load data, combinational
//   led_out        LED register (MMIO offset 0x0004)
//   dmem_err       sticky misaligned-store flag
//   err_addr       address of the first misaligned store since the last clear
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int          ADDR_BITS = 10,
  parameter logic [15:0] MMIO_TAG  = 16'hFFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        dmemsrc,
  input  logic [1:0]  dmem_inchoice,
  input  logic [2:0]  dmem_outchoice,
  input  logic [31:0] dmem_addrin,
  input  logic [31:0] dmem_in,
  output logic [31:0] dmem_out,
  output logic [15:0] led_out,
  output logic        dmem_err,
  output logic [31:0] err_addr
);

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_WORD = 2'b01;
  localparam logic [1:0] ST_HALF = 2'b10;
  localparam logic [1:0] ST_BYTE = 2'b11;

  localparam logic [2:0] LD_W  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_HU = 3'b010;
  localparam logic [2:0] LD_B  = 3'b011;
  localparam logic [2:0] LD_BU = 3'b100;

  // MMIO register slots, indexed by addr[15:2].
  localparam logic [13:0] REG_CNT  = 14'd0;
  localparam logic [13:0] REG_LED  = 14'd1;
  localparam logic [13:0] REG_ERR  = 14'd2;
  localparam logic [13:0] REG_EADR = 14'd3;

  logic [31:0] mem [2**ADDR_BITS];
  logic [31:0] cycle_cnt;

  // ---------------------------------------------------------------------------
  // Address decode and store qualification
  // ---------------------------------------------------------------------------
  logic                 is_mmio;
  logic [ADDR_BITS-1:0] word_idx;
  logic [13:0]          reg_sel;
  logic                 store_req;
  logic                 misaligned;
  logic                 store_ok;
  logic                 word_store;
  logic                 ram_we;
  logic                 cnt_we;
  logic                 led_we;
  logic                 err_clr;
  logic [3:0]           byte_en;
  logic [31:0]          wdata;

  assign is_mmio   = (dmem_addrin[31:16] == MMIO_TAG);
  // Upper address bits are ignored on purpose, so the RAM aliases.
  assign word_idx  = dmem_addrin[ADDR_BITS+1:2];
  assign reg_sel   = dmem_addrin[15:2];
  assign store_req = dmemsrc && (dmem_inchoice != ST_NONE);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    misaligned = 1'b0;
    if (store_req) begin
      case (dmem_inchoice)
        ST_WORD: misaligned = (dmem_addrin[1:0] != 2'b00);
        ST_HALF: misaligned = dmem_addrin[0];
        default: misaligned = 1'b0;
      endcase
    end
  end

  assign store_ok   = store_req && !misaligned;
  assign word_store = store_ok && (dmem_inchoice == ST_WORD);
  assign ram_we     = store_ok && !is_mmio;
  // Only aligned word stores reach MMIO registers; sub-word ones are dropped.
  assign cnt_we     = word_store && is_mmio && (reg_sel == REG_CNT);
  assign led_we     = word_store && is_mmio && (reg_sel == REG_LED);
  assign err_clr    = word_store && is_mmio && (reg_sel == REG_ERR);

  // Lane enables plus replicated write data, so each lane sees its own bytes.
  always_comb begin
    byte_en = 4'b0000;
    wdata   = dmem_in;
    case (dmem_inchoice)
      ST_WORD: byte_en = 4'b1111;
      ST_HALF: begin
        byte_en = dmem_addrin[1] ? 4'b1100 : 4'b0011;
        wdata   = {2{dmem_in[15:0]}};
      end
      ST_BYTE: begin
        byte_en = 4'b0001 << dmem_addrin[1:0];
        wdata   = {4{dmem_in[7:0]}};
      end
      default: byte_en = 4'b0000;
    endcase
  end

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  // NOTE: the RAM array has no reset. This lets it map onto block RAM. The
  // write is still gated by reset, so a store that lands during reset is lost.
  always_ff @(posedge clk) begin
    if (ram_we && !reset) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // MMIO registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only. This keeps
  // every register sampling the same pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt <= '0;
    end else if (cnt_we) begin
      // A written value beats the increment; counting resumes next edge.
      cycle_cnt <= dmem_in;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_out <= '0;
    end else if (led_we) begin
      led_out <= dmem_in[15:0];
    end
  end

  // The first misaligned address is kept until an explicit clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dmem_err <= 1'b0;
      err_addr <= '0;
    end else if (misaligned) begin
      if (!dmem_err) begin
        dmem_err <= 1'b1;
        err_addr <= dmem_addrin;
      end
    end else if (err_clr) begin
      dmem_err <= 1'b0;
      err_addr <= '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Load path (combinational)
  // ---------------------------------------------------------------------------
  logic [31:0] rd_word;
  logic [15:0] rd_half;
  logic [7:0]  rd_byte;

  always_comb begin
    rd_word = '0;
    if (is_mmio) begin
      case (reg_sel)
        REG_CNT:  rd_word = cycle_cnt;
        REG_LED:  rd_word = {16'b0, led_out};
        REG_ERR:  rd_word = {31'b0, dmem_err};
        REG_EADR: rd_word = err_addr;
        default:  rd_word = '0;
      endcase
    end else begin
      rd_word = mem[word_idx];
    end
  end

  assign rd_half = dmem_addrin[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    rd_byte = rd_word[7:0];
    case (dmem_addrin[1:0])
      2'b00: rd_byte = rd_word[7:0];
      2'b01: rd_byte = rd_word[15:8];
      2'b10: rd_byte = rd_word[23:16];
      2'b11: rd_byte = rd_word[31:24];
      default: rd_byte = rd_word[7:0];
    endcase
  end

  always_comb begin
    dmem_out = '0;
    if (dmemsrc && !reset) begin
      case (dmem_outchoice)
        LD_W:    dmem_out = rd_word;
        LD_H:    dmem_out = {{16{rd_half[15]}}, rd_half};
        LD_HU:   dmem_out = {16'b0, rd_half};
        LD_B:    dmem_out = {{24{rd_byte[7]}}, rd_byte};
        LD_BU:   dmem_out = {24'b0, rd_byte};
        default: dmem_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dmem_ctrl
// Self-checking bench for dmem_ctrl. A vector table drives the RAM and MMIO
// loads and stores. Each vector checks dmem_out before the edge, which is also
// the pre-store value for a store vector. After the edge it checks led_out,
// dmem_err and err_addr. Hand-written sequences cover the counter, the
// asynchronous reset and a store made during reset.
// -----------------------------------------------------------------------------
module tb_dmem_ctrl;

  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] ST_W    = 2'b01;
  localparam logic [1:0] ST_H    = 2'b10;
  localparam logic [1:0] ST_B    = 2'b11;
  localparam logic [2:0] LW  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LHU = 3'b010;
  localparam logic [2:0] LB  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LNO = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        dmemsrc;
  logic [1:0]  dmem_inchoice;
  logic [2:0]  dmem_outchoice;
  logic [31:0] dmem_addrin;
  logic [31:0] dmem_in;
  logic [31:0] dmem_out;
  logic [15:0] led_out;
  logic        dmem_err;
  logic [31:0] err_addr;

  int n_tests = 0;
  int n_fail  = 0;

  dmem_ctrl #(.ADDR_BITS(10), .MMIO_TAG(16'hFFFF)) dut (
    .clk            (clk),
    .reset          (reset),
    .dmemsrc        (dmemsrc),
    .dmem_inchoice  (dmem_inchoice),
    .dmem_outchoice (dmem_outchoice),
    .dmem_addrin    (dmem_addrin),
    .dmem_in        (dmem_in),
    .dmem_out       (dmem_out),
    .led_out        (led_out),
    .dmem_err       (dmem_err),
    .err_addr       (err_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        src;
    logic [1:0]  inc;
    logic [2:0]  outc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] exp_out;   // dmem_out before the edge
    logic [15:0] exp_led;   // register state after the edge
    logic        exp_err;
    logic [31:0] exp_eaddr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic src, logic [1:0] inc, logic [2:0] outc,
                              logic [31:0] addr, logic [31:0] data,
                              logic [31:0] exp_out, logic [15:0] exp_led,
                              logic exp_err, logic [31:0] exp_eaddr);
    vec_t v;
    v.src = src; v.inc = inc; v.outc = outc; v.addr = addr; v.data = data;
    v.exp_out = exp_out; v.exp_led = exp_led; v.exp_err = exp_err;
    v.exp_eaddr = exp_eaddr;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic src, input logic [1:0] inc,
                       input logic [2:0] outc, input logic [31:0] addr,
                       input logic [31:0] data);
    dmemsrc        = src;
    dmem_inchoice  = inc;
    dmem_outchoice = outc;
    dmem_addrin    = addr;
    dmem_in        = data;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // RAM region
    vecs.push_back(mk(1, ST_W,    LNO, 32'h1001_0000, 32'h1234_5678, 32'h0,         16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_0000, 32'h0,         32'h1234_5678, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LH,  32'h1001_0000, 32'h0,         32'h0000_5678, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LHU, 32'h1001_0002, 32'h0,         32'h0000_1234, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LB,  32'h1001_0003, 32'h0,         32'h0000_0012, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LBU, 32'h1001_0003, 32'h0,         32'h0000_0012, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LB,  32'h1001_0000, 32'h0,         32'h0000_0078, 16'h0, 0, 32'h0));
    // Masked stores; a load in the same cycle sees pre-store data
    vecs.push_back(mk(1, ST_W,    LW,  32'h1001_0000, 32'hFFFF_FFFF, 32'h1234_5678, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_B,    LW,  32'h1001_0001, 32'h0000_0000, 32'hFFFF_FFFF, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_H,    LBU, 32'h1001_0002, 32'h0000_8001, 32'h0000_00FF, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_0000, 32'h0,         32'h8001_00FF, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LH,  32'h1001_0002, 32'h0,         32'hFFFF_8001, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LBU, 32'h1001_0001, 32'h0,         32'h0000_0000, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LB,  32'h1001_0000, 32'h0,         32'hFFFF_FFFF, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_0003, 32'h0,         32'h8001_00FF, 16'h0, 0, 32'h0));
    // Misaligned stores: no write, first address kept
    vecs.push_back(mk(1, ST_W,    LNO, 32'h1001_0004, 32'hA5A5_A5A5, 32'h0,         16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_W,    LNO, 32'h1001_0006, 32'h0,         32'h0,         16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_H,    LNO, 32'h1001_0001, 32'h0,         32'h0,         16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_0004, 32'h0,         32'hA5A5_A5A5, 16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_0000, 32'h0,         32'h8001_00FF, 16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_NONE, LW,  32'hFFFF_0008, 32'h0,         32'h0000_0001, 16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_NONE, LW,  32'hFFFF_000C, 32'h0,         32'h1001_0006, 16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_1004, 32'h0,         32'hA5A5_A5A5, 16'h0, 1, 32'h1001_0006));
    vecs.push_back(mk(1, ST_W,    LW,  32'hFFFF_0008, 32'h0,         32'h0000_0001, 16'h0, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'hFFFF_0008, 32'h0,         32'h0,         16'h0, 0, 32'h0));
    // LED register and the other MMIO offsets
    vecs.push_back(mk(1, ST_W,    LNO, 32'hFFFF_0004, 32'hABCD_1234, 32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'hFFFF_0004, 32'h0,         32'h0000_1234, 16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LBU, 32'hFFFF_0005, 32'h0,         32'h0000_0012, 16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_H,    LNO, 32'hFFFF_0004, 32'h0000_FFFF, 32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_B,    LNO, 32'hFFFF_0007, 32'h0,         32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'hFFFF_0010, 32'h0,         32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(0, ST_NONE, LW,  32'hFFFF_0004, 32'h0,         32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(0, ST_W,    LW,  32'hFFFF_0004, 32'h0,         32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_W,    LW,  32'h1001_0004, 32'h1111_1111, 32'hA5A5_A5A5, 16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'h1001_0004, 32'h0,         32'h1111_1111, 16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_W,    LW,  32'hFFFF_000C, 32'hDEAD_BEEF, 32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_NONE, LW,  32'hFFFF_000C, 32'h0,         32'h0,         16'h1234, 0, 32'h0));
    vecs.push_back(mk(1, ST_H,    LNO, 32'hFFFF_0003, 32'h0,         32'h0,         16'h1234, 1, 32'hFFFF_0003));
    vecs.push_back(mk(1, ST_NONE, 3'b101, 32'h1001_0000, 32'h0,      32'h0,         16'h1234, 1, 32'hFFFF_0003));

    // Reset state; a load during reset returns 0
    reset = 1'b1;
    drive(1, ST_NONE, LW, 32'hFFFF_0004, 32'h0);
    #1;
    check("reset_out", dmem_out, 32'h0);
    check("reset_led", {16'h0, led_out}, 32'h0);
    check("reset_err", {31'h0, dmem_err}, 32'h0);
    check("reset_eaddr", err_addr, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // Table
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].src, vecs[i].inc, vecs[i].outc, vecs[i].addr, vecs[i].data);
      #1;
      check($sformatf("v%0d_out", i), dmem_out, vecs[i].exp_out);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_led", i), {16'h0, led_out}, {16'h0, vecs[i].exp_led});
      check($sformatf("v%0d_err", i), {31'h0, dmem_err}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d_eaddr", i), err_addr, vecs[i].exp_eaddr);
    end

    // Asynchronous reset mid-cycle (led=0x1234, err=1 from the table)
    @(negedge clk);
    drive(1, ST_NONE, LW, 32'hFFFF_0000, 32'h0);
    #1 reset = 1'b1;
    #1;
    check("async_led", {16'h0, led_out}, 32'h0);
    check("async_err", {31'h0, dmem_err}, 32'h0);
    check("async_eaddr", err_addr, 32'h0);
    check("async_out", dmem_out, 32'h0);
    #1 reset = 1'b0;
    #1;
    check("async_cnt", dmem_out, 32'h0);

    // Counter write, then increment and wrap
    @(negedge clk);
    drive(1, ST_W, LNO, 32'hFFFF_0000, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    drive(1, ST_NONE, LW, 32'hFFFF_0000, 32'h0);
    #1;
    check("cnt_n", dmem_out, 32'hFFFF_FFFE);
    @(posedge clk);
    #1;
    check("cnt_n1", dmem_out, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    check("cnt_n2_wrap", dmem_out, 32'h0000_0000);
    @(posedge clk);
    #1;
    check("cnt_n3", dmem_out, 32'h0000_0001);

    // Stores held across an edge during reset are lost
    @(negedge clk);
    drive(1, ST_W, LNO, 32'h1001_0008, 32'h5555_5555);
    @(negedge clk);
    reset = 1'b1;
    drive(1, ST_W, LNO, 32'h1001_0008, 32'h9999_9999);
    @(negedge clk);
    drive(1, ST_W, LNO, 32'hFFFF_0004, 32'h0000_4321);
    @(negedge clk);
    reset = 1'b0;
    drive(1, ST_NONE, LW, 32'h1001_0008, 32'h0);
    #1;
    check("rst_store_ram", dmem_out, 32'h5555_5555);
    check("rst_store_led", {16'h0, led_out}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-memory responder that completes the CPU's data-memory port: it accepts the CPU's address, store data, store-width select and load-width/sign select, and serves word/halfword/byte stores into an internal RAM and sign/zero-extended loads out of it. It also decodes a small memory-mapped I/O window holding a free-running cycle counter, an LED output register and a sticky misalignment-error record. It sits beside the CPU at the top level, in place of a bare RAM.

## Interface
- ADDR_BITS, 10, log2 of RAM depth in words (RAM = 2^ADDR_BITS x 32 bit)
- MMIO_TAG, 16'hFFFF, value of addr[31:16] that selects the MMIO window

- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high; one clock, no other clock or reset in the block
- dmemsrc  in  1  access enable; 0 = no access, loads return 0, stores ignored
- dmem_inchoice  in  2  store width: 00 none, 01 word, 10 halfword, 11 byte
- dmem_outchoice  in  3  load mode: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu, others return 0
- dmem_addrin  in  32  byte address
- dmem_in  in  32  store data; halfword/byte taken from low bits
- dmem_out  out  32  load data, combinational from current state
- led_out  out  16  LED register, low half of MMIO 0xFFFF0004
- dmem_err  out  1  sticky misaligned-store flag
- err_addr  out  32  address of the first misaligned store since last clear

## Operation
- Decode: addr[31:16]==MMIO_TAG -> MMIO; else RAM, word index addr[ADDR_BITS+1:2] (upper bits ignored, aliasing intended).
- Byte order little-endian: addr[1:0]=00 is bits[7:0], 11 is bits[31:24]; halfword at addr[1]=0 is bits[15:0].
- Store (dmemsrc=1, inchoice!=00): on rising clk, writes only addressed byte lanes; other lanes keep value.
- Alignment: word store needs addr[1:0]=00, halfword needs addr[0]=0. Misaligned store: no lanes written; if dmem_err=0, set dmem_err=1 and err_addr=addr; if already 1, err_addr keeps the first address.
- Load: select addressed word, extract lane per outchoice; lh/lb sign-extend, lhu/lbu zero-extend. Misaligned loads are not flagged; lw ignores addr[1:0], lh/lhu ignores addr[0].
- MMIO map (word offsets, addr[15:0]):
  - 0x0000 cycle counter: 32-bit, +1 every clk, wraps 0xFFFFFFFF->0. Word store loads dmem_in.
  - 0x0004 LED: word store loads led_out=dmem_in[15:0]; read returns {16'b0,led_out}.
  - 0x0008 error: read returns {31'b0,dmem_err}; any aligned word store clears dmem_err and err_addr.
  - 0x000C error address: read returns err_addr; read-only.
  - Other MMIO offsets: loads return 0, stores ignored. Halfword/byte stores to MMIO ignored (not flagged if aligned). Sub-word loads extract from register value like RAM.
- Simultaneous events: counter write and increment on same edge -> written value wins, increments next edge. Misaligned store and error-clear cannot coincide (single port).

## Timing
- Reset (async, immediate): counter=0, led_out=0, dmem_err=0, err_addr=0. RAM contents not reset (undefined until written).
- dmem_out=0 whenever dmemsrc=0 or reset=1.
- Store: single cycle, visible to a load of the same address in the next cycle; a load in the same cycle as a store returns pre-store data.
- Load latency: zero cycles (combinational through address, select and extend).
- Counter read returns registered value; two back-to-back reads differ by 1.
- Reset asserted mid-store: the store is lost for MMIO registers; RAM write on that edge is suppressed.

## Test plan
- sw 0x12345678 to 0x10010000, then lw/lh/lhu/lb/lbu at +0,+2,+3 -> 0x12345678, 0x00005678, 0x00001234, 0x00000012, 0x00000012.
- sw 0xFFFFFFFF, then sb 0x00 to +1 and sh 0x8001 to +2 -> lw 0x800100FF; lh +2 -> 0xFFFF8001; lbu +1 -> 0x00000000.
- sw to 0x10010006 then sh to 0x10010001 -> RAM unchanged, dmem_err=1, err_addr=0x10010006; sw to 0xFFFF0008 -> dmem_err=0, err_addr=0.
- Reset, sw 0xFFFFFFFE to 0xFFFF0000 on edge N -> counter reads 0xFFFFFFFF after N+1, 0x00000000 after N+2.
- sw 0xABCD1234 to 0xFFFF0004 -> led_out=0x1234; lw from it -> 0x00001234; lw 0xFFFF0010 -> 0; dmemsrc=0 -> dmem_out=0.
- Assert reset asynchronously mid-cycle with led_out=0x1234, dmem_err=1 -> led_out, dmem_err, err_addr, counter all 0 before next clk edge.
